dls_recovery_ctrl: RTL and testbench

Controller for the dual-lockstep VGA pair. Watches the comparator's DLS_ERROR and confirms persistent mismatches. On a confirmed mismatch it blanks the display, then re-synchronises both VGA channels with a shared local reset. After repeated failures within a time window it latches a fault. Exposes control, status and an error counter as a small AHB-Lite slave on the same bus as the VGA peripheral.

---
 rtl/dls_ctrl_pkg.sv | 27 ++
 rtl/dls_ctrl_ahb_regs.sv | 77 +++++++
 rtl/dls_recovery_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dls_recovery_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dls_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dls_ctrl_pkg
// Brief   : Shared types and register-map constants for the DLS recovery ctrl.
// Revision: 1.0 - initial release
// ============================================================================
package dls_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_RESYNC  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_FAULT   = 3'd4
  } dls_state_t;

  // Word offsets, i.e. HADDR[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_ERRCNT = 2'd2;

  localparam int CTRL_EN           = 0;
  localparam int CTRL_CLR_FAULT    = 1;
  localparam int CTRL_FORCE_RESYNC = 2;

endpackage
`default_nettype wire

// File: rtl/dls_ctrl_ahb_regs.sv
`default_nettype none
// ============================================================================
// Module  : dls_ctrl_ahb_regs
// Brief   : Zero-wait AHB-Lite register slice: CTRL/STATUS/ERR_CNT decode.
// Revision: 1.0 - initial release
// ============================================================================
module dls_ctrl_ahb_regs
  import dls_ctrl_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        i_sel,
  input  logic        i_ready,
  input  logic [1:0]  i_addr,
  input  logic        i_write,
  input  logic [2:0]  i_wdata,
  input  dls_state_t  i_state,
  input  logic        i_fault,
  input  logic [3:0]  i_retry,
  input  logic [15:0] i_err_cnt,
  output logic [31:0] o_rdata,
  output logic        o_en,
  output logic        o_clr_fault,
  output logic        o_force_resync,
  output logic        o_errcnt_clr
);

  logic       r_dp_valid;
  logic       r_dp_write;
  logic [1:0] r_dp_addr;
  logic       r_en;
  logic       w_wr;
  logic       w_wr_ctrl;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= 2'd0;
    end else if (i_ready) begin
      r_dp_valid <= i_sel;
      r_dp_write <= i_write;
      r_dp_addr  <= i_addr;
    end
  end

  assign w_wr      = r_dp_valid & r_dp_write;
  assign w_wr_ctrl = w_wr & (r_dp_addr == REG_CTRL);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_en <= 1'b1;
    end else if (w_wr_ctrl) begin
      r_en <= i_wdata[CTRL_EN];
    end
  end

  // Write-1 strobes are live only for the data phase, so they self-clear.
  assign o_en           = r_en;
  assign o_clr_fault    = w_wr_ctrl & i_wdata[CTRL_CLR_FAULT];
  assign o_force_resync = w_wr_ctrl & i_wdata[CTRL_FORCE_RESYNC];
  assign o_errcnt_clr   = w_wr & (r_dp_addr == REG_ERRCNT);

  always_comb begin
    o_rdata = 32'd0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_addr)
        REG_CTRL:   o_rdata = {31'd0, r_en};
        REG_STATUS: o_rdata = {24'd0, i_retry, i_fault, i_state};
        REG_ERRCNT: o_rdata = {16'd0, i_err_cnt};
        default:    o_rdata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dls_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dls_recovery_ctrl
// Brief   : Confirms lockstep mismatches, blanks and resyncs the VGA pair.
// Revision: 1.0 - initial release
// ============================================================================
module dls_recovery_ctrl
  import dls_ctrl_pkg::*;
#(
  parameter int CONFIRM_CYC = 4,
  parameter int RST_CYC     = 16,
  parameter int SETTLE_CYC  = 32,
  parameter int MAX_RETRY   = 3,
  parameter int WINDOW_CYC  = 1048576
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        DLS_ERROR,
  output logic        VGA_RSTn,
  output logic        BLANK,
  output logic        DLS_FAULT,
  output logic        IRQ
);

  localparam int WIN_W = $clog2(WINDOW_CYC + 1);

  localparam logic [7:0]       c_confirm     = 8'(CONFIRM_CYC);
  localparam logic [7:0]       c_rst_last    = 8'(RST_CYC - 1);
  localparam logic [7:0]       c_settle_last = 8'(SETTLE_CYC - 1);
  localparam logic [3:0]       c_max_retry   = 4'(MAX_RETRY);
  localparam logic [WIN_W-1:0] c_win_last    = WIN_W'(WINDOW_CYC - 1);

  dls_state_t       r_state, w_state_nx;
  logic             r_err_q;
  logic [7:0]       r_cnt, w_cnt_nx, w_cnt_inc;
  logic [7:0]       r_tmr, w_tmr_nx;
  logic [3:0]       r_retry, w_retry_nx;
  logic [WIN_W-1:0] r_win, w_win_nx;
  logic [15:0]      r_err_cnt, w_err_cnt_nx;
  logic             r_irq, w_confirm;
  logic             w_en, w_clr_fault, w_force, w_errcnt_clr;
  logic             w_unused_bits;

  assign w_unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:3]};

  dls_ctrl_ahb_regs u_regs (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .i_sel          (HSEL & HTRANS[1]),
    .i_ready        (HREADY),
    .i_addr         (HADDR[3:2]),
    .i_write        (HWRITE),
    .i_wdata        (HWDATA[2:0]),
    .i_state        (r_state),
    .i_fault        (DLS_FAULT),
    .i_retry        (r_retry),
    .i_err_cnt      (r_err_cnt),
    .o_rdata        (HRDATA),
    .o_en           (w_en),
    .o_clr_fault    (w_clr_fault),
    .o_force_resync (w_force),
    .o_errcnt_clr   (w_errcnt_clr)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_RUN;
      r_err_q   <= 1'b0;
      r_cnt     <= 8'd0;
      r_tmr     <= 8'd0;
      r_retry   <= 4'd0;
      r_win     <= '0;
      r_err_cnt <= 16'd0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_err_q   <= DLS_ERROR;
      r_cnt     <= w_cnt_nx;
      r_tmr     <= w_tmr_nx;
      r_retry   <= w_retry_nx;
      r_win     <= w_win_nx;
      r_err_cnt <= w_err_cnt_nx;
      r_irq     <= w_confirm;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_tmr_nx   = r_tmr;
    w_retry_nx = r_retry;
    w_win_nx   = r_win;
    w_confirm  = 1'b0;
    w_cnt_inc  = r_cnt + 8'd1;
    case (r_state)
      ST_RUN: begin
        if (w_force) begin
          w_state_nx = ST_RESYNC;
          w_tmr_nx   = 8'd0;
        end else if (w_en && r_err_q) begin
          // A one-cycle confirm threshold is satisfied by this first error.
          w_cnt_nx = 8'd1;
          if (c_confirm <= 8'd1) w_confirm = 1'b1;
          else                   w_state_nx = ST_CONFIRM;
        end else if (!r_err_q) begin
          if (r_win == c_win_last) begin
            w_win_nx   = '0;
            w_retry_nx = 4'd0;
          end else begin
            w_win_nx = r_win + 1'b1;
          end
        end
      end
      ST_CONFIRM: begin
        if (!r_err_q || !w_en) begin
          w_state_nx = ST_RUN;
        end else begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc >= c_confirm) w_confirm = 1'b1;
        end
      end
      ST_RESYNC: begin
        if (r_tmr == c_rst_last) begin
          w_state_nx = ST_SETTLE;
          w_tmr_nx   = 8'd0;
        end else begin
          w_tmr_nx = r_tmr + 8'd1;
        end
      end
      ST_SETTLE: begin
        w_win_nx = '0;
        if (r_tmr == c_settle_last) begin
          w_state_nx = ST_RUN;
          w_tmr_nx   = 8'd0;
        end else begin
          w_tmr_nx = r_tmr + 8'd1;
        end
      end
      ST_FAULT: begin
        if (w_clr_fault) begin
          w_state_nx = ST_RESYNC;
          w_tmr_nx   = 8'd0;
          w_retry_nx = 4'd0;
        end
      end
      default: w_state_nx = ST_RUN;
    endcase

    if (w_confirm) begin
      w_tmr_nx = 8'd0;
      if (r_retry == c_max_retry) begin
        w_state_nx = ST_FAULT;
      end else begin
        w_retry_nx = r_retry + 4'd1;
        w_state_nx = ST_RESYNC;
      end
    end
  end

  // A software clear takes priority over a coincident increment.
  always_comb begin
    w_err_cnt_nx = r_err_cnt;
    if (w_errcnt_clr)                          w_err_cnt_nx = 16'd0;
    else if (w_confirm && r_err_cnt != 16'hFFFF) w_err_cnt_nx = r_err_cnt + 16'd1;
  end

  assign HREADYOUT = 1'b1;
  assign BLANK     = (r_state != ST_RUN);
  assign DLS_FAULT = (r_state == ST_FAULT);
  assign VGA_RSTn  = HRESETn & (r_state != ST_RESYNC) & (r_state != ST_FAULT);
  assign IRQ       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_dls_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dls_recovery_ctrl
// Brief   : Directed and randomized checks of dls_recovery_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dls_recovery_ctrl;

  localparam int CONF  = 4;
  localparam int RSTC  = 16;
  localparam int SETC  = 32;
  localparam int MAXR  = 3;
  localparam int WIN   = 64;
  // Edges from the DLS_ERROR rise until the controller is back in RUN.
  localparam int RECOVER = CONF + 1 + RSTC + SETC;

  logic        HCLK = 1'b0;
  logic        HRESETn, HSEL, HREADY, HWRITE, DLS_ERROR;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, VGA_RSTn, BLANK, DLS_FAULT, IRQ;

  int checks = 0;
  int errors = 0;
  int n_rstlow, n_blank, n_irq;
  int m_retry, m_win, m_errcnt;
  bit m_fault;
  logic [31:0] rd;

  dls_recovery_ctrl #(
    .CONFIRM_CYC (CONF),
    .RST_CYC     (RSTC),
    .SETTLE_CYC  (SETC),
    .MAX_RETRY   (MAXR),
    .WINDOW_CYC  (WIN)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HREADY    (HREADY),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .DLS_ERROR (DLS_ERROR),
    .VGA_RSTn  (VGA_RSTn),
    .BLANK     (BLANK),
    .DLS_FAULT (DLS_FAULT),
    .IRQ       (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    if (!VGA_RSTn) n_rstlow++;
    if (BLANK)     n_blank++;
    if (IRQ)       n_irq++;
  endtask

  task automatic clr_counts();
    n_rstlow = 0;
    n_blank  = 0;
    n_irq    = 0;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    tick();
  endtask

  task automatic burst(input int len, input int gap);
    DLS_ERROR = 1'b1;
    repeat (len) tick();
    DLS_ERROR = 1'b0;
    repeat (gap) tick();
  endtask

  // Reference: count error-free RUN cycles; a full window forgives retries.
  task automatic win_add(input int n);
    for (int k = 0; k < n; k++) begin
      m_win++;
      if (m_win >= WIN) begin
        m_win   = 0;
        m_retry = 0;
      end
    end
  endtask

  function automatic logic [31:0] status_exp(input bit fault, input int retry);
    return fault ? (32'h4 | 32'h8 | (retry << 4)) : (retry << 4);
  endfunction

  initial begin
    int n, len, gap;
    bit conf;
    HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HADDR = '0; HTRANS = 2'b00;
    HWRITE = 1'b0; HWDATA = '0; DLS_ERROR = 1'b0;
    clr_counts();
    #1;
    check("rst_vga_rstn", {31'd0, VGA_RSTn}, 32'd0);
    check("rst_blank", {31'd0, BLANK}, 32'd0);
    check("rst_fault", {31'd0, DLS_FAULT}, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    repeat (2) tick();
    HRESETn = 1'b1;
    tick();
    check("run_vga_rstn", {31'd0, VGA_RSTn}, 32'd1);
    ahb_read(32'h0, rd); check("ctrl_reset", rd, 32'h1);
    ahb_read(32'h4, rd); check("status_reset", rd, 32'h0);
    ahb_read(32'hC, rd); check("reg_c_reads_0", rd, 32'h0);

    // Short glitch: CONFIRM then back to RUN without counting
    clr_counts();
    burst(2, 10);
    check("glitch_irq", n_irq, 0);
    check("glitch_rstlow", n_rstlow, 0);
    check("glitch_blank", n_blank, 2);
    ahb_read(32'h8, rd); check("glitch_errcnt", rd, 32'h0);
    ahb_read(32'h4, rd); check("glitch_status", rd, 32'h0);

    // Persistent error: IRQ latency, reset pulse width, blanking span
    clr_counts();
    DLS_ERROR = 1'b1;
    n = 0;
    while (IRQ !== 1'b1 && n < 20) begin tick(); n++; end
    check("irq_latency", n, CONF + 1);
    DLS_ERROR = 1'b0;
    repeat (60) tick();
    check("confirm_irq_count", n_irq, 1);
    check("confirm_rstlow", n_rstlow, RSTC);
    check("confirm_blank", n_blank, CONF - 1 + RSTC + SETC);
    ahb_read(32'h8, rd); check("confirm_errcnt", rd, 32'h1);
    ahb_read(32'h4, rd); check("confirm_status", rd, 32'h10);

    // Three more confirmed errors: the fourth one latches FAULT
    burst(6, 60);
    burst(6, 60);
    ahb_read(32'h4, rd); check("retry3_status", rd, 32'h30);
    burst(6, 60);
    check("fault_out", {31'd0, DLS_FAULT}, 32'd1);
    check("fault_vga_rstn", {31'd0, VGA_RSTn}, 32'd0);
    check("fault_blank", {31'd0, BLANK}, 32'd1);
    ahb_read(32'h4, rd); check("fault_status", rd, 32'h3C);
    ahb_read(32'h8, rd); check("fault_errcnt", rd, 32'h4);
    ahb_write(32'h0, 32'h5);
    ahb_read(32'h4, rd); check("fault_ignores_force", rd, 32'h3C);
    ahb_write(32'h0, 32'h2);
    ahb_read(32'h4, rd); check("clr_fault_resync", rd, 32'h02);
    repeat (60) tick();
    ahb_read(32'h4, rd); check("clr_fault_run", rd, 32'h00);
    ahb_read(32'h0, rd); check("ctrl_en_off", rd, 32'h0);

    // EN=0: errors ignored; then forced resync re-enables
    clr_counts();
    DLS_ERROR = 1'b1;
    repeat (100) tick();
    ahb_read(32'h4, rd); check("en0_status", rd, 32'h0);
    DLS_ERROR = 1'b0;
    repeat (2) tick();
    check("en0_blank", n_blank, 0);
    check("en0_irq", n_irq, 0);
    clr_counts();
    ahb_write(32'h0, 32'h5);
    repeat (60) tick();
    check("force_rstlow", n_rstlow, RSTC);
    check("force_irq", n_irq, 0);
    ahb_read(32'h8, rd); check("force_errcnt", rd, 32'h4);
    ahb_read(32'h4, rd); check("force_status", rd, 32'h0);
    ahb_read(32'h0, rd); check("force_ctrl", rd, 32'h1);

    // Window expiry forgives the retry, then ERR_CNT clear
    burst(6, 60);
    ahb_read(32'h4, rd); check("win_before", rd, 32'h10);
    repeat (60) tick();
    ahb_read(32'h4, rd); check("win_after", rd, 32'h00);
    ahb_read(32'h8, rd); check("errcnt_before_clr", rd, 32'h5);
    ahb_write(32'h8, 32'hFFFF);
    ahb_read(32'h8, rd); check("errcnt_cleared", rd, 32'h0);

    // Asynchronous reset in the middle of RESYNC
    burst(6, 3);
    check("resync_vga_rstn", {31'd0, VGA_RSTn}, 32'd0);
    HRESETn = 1'b0;
    #1;
    check("arst_vga_rstn", {31'd0, VGA_RSTn}, 32'd0);
    check("arst_blank", {31'd0, BLANK}, 32'd0);
    check("arst_fault", {31'd0, DLS_FAULT}, 32'd0);
    check("arst_irq", {31'd0, IRQ}, 32'd0);
    check("arst_hrdata", HRDATA, 32'd0);
    tick();
    HRESETn = 1'b1;
    repeat (2) tick();
    check("arst_rel_vga", {31'd0, VGA_RSTn}, 32'd1);
    ahb_read(32'h4, rd); check("arst_status", rd, 32'h0);
    ahb_read(32'h0, rd); check("arst_ctrl", rd, 32'h1);
    ahb_read(32'h8, rd); check("arst_errcnt", rd, 32'h0);

    // Randomized bursts against the event-level reference model
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    m_retry = 0; m_win = 0; m_errcnt = 0; m_fault = 1'b0;
    repeat (2) tick();
    win_add(2);
    for (int s = 0; s < 30; s++) begin
      len  = $urandom_range(1, 10);
      conf = (len >= CONF);
      gap  = conf ? $urandom_range(60, 80) : $urandom_range(2, 40);
      clr_counts();
      burst(len, gap);
      win_add(1);
      if (conf) begin
        m_errcnt++;
        if (m_retry == MAXR) begin
          m_fault = 1'b1;
        end else begin
          m_retry++;
          m_win = 0;
          win_add(len + gap - RECOVER);
        end
      end else begin
        win_add(gap - 2);
      end
      check("rnd_irq", n_irq, conf ? 1 : 0);
      check("rnd_fault", {31'd0, DLS_FAULT}, {31'd0, m_fault});
      if (!conf) check("rnd_glitch_blank", n_blank, len);
      else if (!m_fault) check("rnd_rstlow", n_rstlow, RSTC);
      if (!m_fault) win_add(1);
      ahb_read(32'h4, rd);
      check("rnd_status", rd, status_exp(m_fault, m_retry));
      if (!m_fault) win_add(1);
      ahb_read(32'h8, rd);
      check("rnd_errcnt", rd, m_errcnt);
      if (!m_fault) win_add(2);
      if (m_fault) begin
        ahb_write(32'h0, 32'h3);
        repeat (60) tick();
        m_fault = 1'b0;
        m_retry = 0;
        m_win   = 0;
        win_add(2 + 60 - (2 + RSTC + SETC));
        win_add(1);
        ahb_read(32'h4, rd);
        check("rnd_recover_status", rd, status_exp(1'b0, m_retry));
        win_add(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
